// File: rtl/adc_avg_filter_if.sv
// Sample/output bundle between the ADC front end, the
// averaging filter and the DAC side.
interface adc_avg_filter_if #(
  parameter int DATA_W    = 8,
  parameter int LOG2_TAPS = 3
);
  logic                 sample_en;
  logic [DATA_W-1:0]    adin_data;
  logic [DATA_W-1:0]    daout_data;
  logic                 out_valid;
  logic [LOG2_TAPS:0]   win_count;

  modport master (
    output sample_en,
    output adin_data,
    input  daout_data,
    input  out_valid,
    input  win_count
  );

  modport slave (
    input  sample_en,
    input  adin_data,
    output daout_data,
    output out_valid,
    output win_count
  );
endinterface

// File: rtl/adc_avg_filter.sv
// Boxcar moving average between ADC and DAC with a running-sum
// accumulator and a post-reset discard of ADC pipeline samples.
module adc_avg_filter #(
  parameter int DATA_W    = 8,
  parameter int LOG2_TAPS = 3,
  parameter int ADC_LAT   = 3
) (
  input  logic GLOBAL_CLK,
  input  logic RESET,
  adc_avg_filter_if.slave bus
);

  localparam int TAPS = 1 << LOG2_TAPS;
  localparam int SW   = DATA_W + LOG2_TAPS;
  localparam int CW   = (ADC_LAT > 0) ? $clog2(ADC_LAT + 1) : 1;
  localparam logic [LOG2_TAPS:0] FULL = (LOG2_TAPS + 1)'(TAPS);

  logic [DATA_W-1:0]    win_buf [TAPS];
  logic [LOG2_TAPS-1:0] wp;
  logic [SW-1:0]        sum;
  logic [CW-1:0]        disc;
  logic [LOG2_TAPS:0]   cnt;
  logic                 upd;
  logic [DATA_W-1:0]    dout;
  logic                 valid;
  logic                 discarding;

  assign discarding = ($unsigned(32'(disc)) < $unsigned(ADC_LAT));

  always_ff @(posedge GLOBAL_CLK) begin
    if (RESET) begin
      for (int i = 0; i < TAPS; i++) begin
        win_buf[i] <= '0;
      end
      wp    <= '0;
      sum   <= '0;
      disc  <= '0;
      cnt   <= '0;
      upd   <= 1'b0;
      dout  <= '0;
      valid <= 1'b0;
    end else begin
      upd <= 1'b0;
      // output stage lags the accumulator by one edge
      if (upd) begin
        dout  <= DATA_W'(sum >> LOG2_TAPS);
        valid <= valid | (cnt == FULL);
      end
      if (bus.sample_en) begin
        if (discarding) begin
          disc <= disc + CW'(1);
        end else begin
          win_buf[wp] <= bus.adin_data;
          sum <= sum + SW'(bus.adin_data) - SW'(win_buf[wp]);
          wp  <= wp + LOG2_TAPS'(1);
          if (cnt != FULL) begin
            cnt <= cnt + (LOG2_TAPS + 1)'(1);
          end
          upd <= 1'b1;
        end
      end
    end
  end

  assign bus.daout_data = dout;
  assign bus.out_valid  = valid;
  assign bus.win_count  = cnt;

endmodule

// File: tb/tb_adc_avg_filter.sv
// Randomized and directed check of adc_avg_filter against a
// sample-history reference model.
module tb_adc_avg_filter;

  localparam int L    = 3;
  localparam int N    = 1 << L;
  localparam int LAT  = 3;

  logic clk  = 1'b0;
  logic rst  = 1'b1;
  logic rst2 = 1'b1;

  always #5 clk = ~clk;

  adc_avg_filter_if #(.DATA_W(8), .LOG2_TAPS(L)) bus ();
  adc_avg_filter_if #(.DATA_W(8), .LOG2_TAPS(1)) bus2 ();

  adc_avg_filter #(.DATA_W(8), .LOG2_TAPS(L), .ADC_LAT(LAT)) dut (
    .GLOBAL_CLK (clk),
    .RESET      (rst),
    .bus        (bus.slave)
  );

  adc_avg_filter #(.DATA_W(8), .LOG2_TAPS(1), .ADC_LAT(0)) dut2 (
    .GLOBAL_CLK (clk),
    .RESET      (rst2),
    .bus        (bus2.slave)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // reference model state
  int m_disc;
  int m_hist[$];
  bit m_pend;
  int m_pend_val;
  bit m_pend_full;
  int e_dout;
  bit e_valid;
  int e_win;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t",
               tag, got, exp, $time);
    end
  endtask

  task automatic model_edge(input bit r, input bit en, input int d);
    int s;
    if (r) begin
      m_disc = 0;
      m_hist.delete();
      m_pend = 0;
      m_pend_val = 0;
      m_pend_full = 0;
      e_dout = 0;
      e_valid = 0;
      e_win = 0;
    end else begin
      if (m_pend) begin
        e_dout  = m_pend_val;
        e_valid = e_valid | m_pend_full;
        m_pend  = 0;
      end
      if (en) begin
        if (m_disc < LAT) begin
          m_disc++;
        end else begin
          m_hist.push_back(d);
          if (m_hist.size() > N) void'(m_hist.pop_front());
          s = 0;
          foreach (m_hist[i]) s += m_hist[i];
          m_pend_val  = s / N;
          m_pend_full = (m_hist.size() == N);
          m_pend      = 1;
          e_win       = m_hist.size();
        end
      end
    end
  endtask

  task automatic step(input bit r, input bit en, input int d);
    rst           = r;
    bus.sample_en = en;
    bus.adin_data = 8'(d);
    @(posedge clk);
    model_edge(r, en, d);
    #1;
    check("dout",  32'(bus.daout_data), 32'(e_dout));
    check("valid", 32'(bus.out_valid),  32'(e_valid));
    check("win",   32'(bus.win_count),  32'(e_win));
  endtask

  task automatic step2(input bit r, input bit en, input int d);
    rst2           = r;
    bus2.sample_en = en;
    bus2.adin_data = 8'(d);
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.sample_en  = 1'b0;
    bus.adin_data  = '0;
    bus2.sample_en = 1'b0;
    bus2.adin_data = '0;
    model_edge(1, 0, 0);

    // reset held with live input
    step(1, 1, 'hFF);
    step(1, 1, 'hFF);
    check("rst_dout", 32'(bus.daout_data), 0);
    check("rst_win",  32'(bus.win_count),  0);

    // constant 0x80 ramp after discard
    for (int i = 0; i < 14; i++) step(0, 1, 'h80);
    check("ramp_dout",  32'(bus.daout_data), 'h80);
    check("ramp_valid", 32'(bus.out_valid),  1);
    check("ramp_win",   32'(bus.win_count),  8);

    // reset mid-stream, then ramp repeats
    step(1, 1, 'h80);
    check("mid_rst_valid", 32'(bus.out_valid), 0);
    for (int i = 0; i < 14; i++) step(0, 1, 'h80);

    // window of zeros then step to 0xFF
    for (int i = 0; i < N; i++) step(0, 1, 'h00);
    step(0, 0, 'h00);
    check("zero_dout", 32'(bus.daout_data), 0);
    for (int i = 0; i < N + 3; i++) step(0, 1, 'hFF);
    check("step_dout", 32'(bus.daout_data), 'hFF);

    // window of 0x40, then gapped 0xC0 samples
    for (int i = 0; i < N + 1; i++) step(0, 1, 'h40);
    for (int i = 0; i < 2 * N + 2; i++)
      step(0, (i % 2) == 0, (i % 2) == 0 ? 'hC0 : 32'($urandom_range(255)));
    check("gap_dout", 32'(bus.daout_data), 'hC0);

    // randomized traffic with occasional resets
    for (int i = 0; i < 400; i++)
      step($urandom_range(59) == 0, $urandom_range(3) != 0,
           32'($urandom_range(255)));

    // two-tap filter without discard
    step2(1, 0, 0);
    check("t2_rst_dout", 32'(bus2.daout_data), 0);
    step2(0, 1, 'h10);
    check("t2_win1", 32'(bus2.win_count), 1);
    step2(0, 1, 'h30);
    check("t2_dout0", 32'(bus2.daout_data), 'h08);
    check("t2_valid0", 32'(bus2.out_valid), 0);
    step2(0, 0, 'hAA);
    check("t2_dout1", 32'(bus2.daout_data), 'h20);
    check("t2_valid1", 32'(bus2.out_valid), 1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
